// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between the instruction-fetch port and
// the data load/store port. A single registered FSM grants one requester at a
// time, issues a one-cycle read/write strobe, waits for the bus to go idle,
// returns the captured data with a one-cycle ready pulse and aborts stuck
// transfers with a watchdog.
module bus_arbiter (
   input  logic        clk,
   input  logic        nRST,
   input  logic        imemRead,
   input  logic [31:0] imemAddr,
   input  logic        dmemRead,
   input  logic        dmemWrite,
   input  logic [31:0] dmemAddr,
   input  logic [31:0] dmemStore,
   input  logic        busy_o,
   input  logic [31:0] bus_rdata,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   output logic        read_o,
   output logic        write_o,
   output logic [31:0] instr,
   output logic [31:0] dmemLoad,
   output logic        iready,
   output logic        dready,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IREQ  = 3'd1,
      DREQ  = 3'd2,
      IWAIT = 3'd3,
      DWAIT = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Encoding of the grant history bit
   localparam logic FETCH = 1'b0;
   localparam logic DATA  = 1'b1;

   // Watchdog abort point: the 255th busy cycle spent waiting
   localparam logic [7:0] WD_LAST = 8'd254;

   state_t     state_reg;
   logic       last_grant_reg;   // who won the previous arbitration
   logic [7:0] wd_cnt_reg;       // busy cycles seen in the current WAIT
   logic       dir_read_reg;     // latched direction of the data access

   logic       data_req;
   logic       data_first;

   // A data request wins unless data was granted last and a fetch is waiting,
   // so neither port can starve the other when both are held high.
   assign data_req   = dmemRead | dmemWrite;
   assign data_first = data_req && !((last_grant_reg == DATA) && imemRead);

   // Arbitration FSM; every output is a register updated on the transition
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_reg      <= IDLE;
         last_grant_reg <= FETCH;
         wd_cnt_reg     <= 8'd0;
         dir_read_reg   <= 1'b0;
         adr_o          <= 32'd0;
         dat_o          <= 32'd0;
         read_o         <= 1'b0;
         write_o        <= 1'b0;
         instr          <= 32'd0;
         dmemLoad       <= 32'd0;
         iready         <= 1'b0;
         dready         <= 1'b0;
         err            <= 1'b0;
      end else begin
         // completion pulses last exactly one cycle
         iready <= 1'b0;
         dready <= 1'b0;
         err    <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (data_first) begin
                  // latch the whole data request; read wins if both are set
                  state_reg      <= DREQ;
                  last_grant_reg <= DATA;
                  adr_o          <= dmemAddr;
                  dat_o          <= dmemStore;
                  dir_read_reg   <= dmemRead;
                  read_o         <= dmemRead;
                  write_o        <= dmemWrite & ~dmemRead;
               end else if (imemRead) begin
                  state_reg      <= IREQ;
                  last_grant_reg <= FETCH;
                  adr_o          <= imemAddr;
                  read_o         <= 1'b1;
                  write_o        <= 1'b0;
               end
            end

            IREQ: begin
               // strobe is a single cycle; the watchdog restarts for the wait
               read_o     <= 1'b0;
               write_o    <= 1'b0;
               wd_cnt_reg <= 8'd0;
               state_reg  <= IWAIT;
            end

            DREQ: begin
               read_o     <= 1'b0;
               write_o    <= 1'b0;
               wd_cnt_reg <= 8'd0;
               state_reg  <= DWAIT;
            end

            IWAIT: begin
               if (!busy_o) begin
                  instr     <= bus_rdata;
                  iready    <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 8'd1;
                  if (wd_cnt_reg == WD_LAST) begin
                     // give up: no data captured, no ready pulse
                     err       <= 1'b1;
                     state_reg <= IDLE;
                  end
               end
            end

            DWAIT: begin
               if (!busy_o) begin
                  if (dir_read_reg) begin
                     dmemLoad <= bus_rdata;
                  end
                  dready    <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 8'd1;
                  if (wd_cnt_reg == WD_LAST) begin
                     err       <= 1'b1;
                     state_reg <= IDLE;
                  end
               end
            end

            DONE: begin
               // ignore requests for one cycle so a request still held high
               // during the ready pulse is not granted a second time at once
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   logic pulse_q;

   // Simulation guard: completion pulses never overlap and never repeat back to back
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= iready | dready | err;
         assert ($onehot0({iready, dready, err}))
            else $error("bus_arbiter: overlapping completion pulses");
         assert (!(pulse_q && (iready | dready | err)))
            else $error("bus_arbiter: completion pulse on consecutive cycles");
      end
   end
`endif

endmodule
